// File: rtl/memory_handshake_banked.sv
// Single-port SRAM model with valid/ready request and response channels, byte strobes,
// programmable wait states and an out-of-range error flag. Optional MEMH_INIT_CLEAR_EN zero-fills memory after reset.
module memory_handshake_banked #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [WIDTH/8-1:0]    strb_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  err_o
);

   localparam int unsigned STRB_W = WIDTH / 8;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_INIT} state_t;

`ifdef MEMH_INIT_CLEAR_EN
   localparam state_t RST_STATE = S_INIT;
`else
   localparam state_t RST_STATE = S_IDLE;
`endif

   logic [WIDTH-1:0]      mem [DEPTH];

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [STRB_W-1:0]     strb_q;

   logic                  ready_d, resp_valid_d, err_d;
   logic [WIDTH-1:0]      rdata_d;
   logic                  accept, in_range, mem_we;
   logic [IDX_W-1:0]      idx;

`ifdef MEMH_INIT_CLEAR_EN
   logic [IDX_W-1:0]      init_q;
`endif

   assign accept   = valid_i && ready_o;
   assign in_range = 32'(addr_q) < DEPTH;
   assign idx      = IDX_W'(addr_q);

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready_d      = 1'b0;
      resp_valid_d = resp_valid_o;
      rdata_d      = rdata_o;
      err_d        = err_o;
      mem_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               ready_d = 1'b0;
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(WAIT_STATES)) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               if (in_range) begin
                  err_d  = 1'b0;
                  mem_we = wr_q;
                  if (!wr_q) rdata_d = mem[idx];
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready_i) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
               ready_d      = 1'b1;
            end
         end
`ifdef MEMH_INIT_CLEAR_EN
         S_INIT: begin
            if (init_q == IDX_W'(DEPTH - 1)) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RST_STATE;
         cnt_q        <= '0;
         ready_o      <= 1'b0;
         resp_valid_o <= 1'b0;
         rdata_o      <= '0;
         err_o        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_o      <= ready_d;
         resp_valid_o <= resp_valid_d;
         rdata_o      <= rdata_d;
         err_o        <= err_d;
      end
   end

`ifdef MEMH_INIT_CLEAR_EN
   // Clear pointer restarts from word 0 on every reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                  init_q <= '0;
      else if (state_q == S_INIT) init_q <= init_q + IDX_W'(1);
   end
`endif

   // Request payload is only sampled on handshake, so it needs no reset
   always_ff @(posedge clk_i) begin
      if (accept) begin
         wr_q    <= wr_rd_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
         strb_q  <= strb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
`ifdef MEMH_INIT_CLEAR_EN
      if (state_q == S_INIT) mem[init_q] <= '0;
`endif
   end

endmodule
